// File: rtl/stack_pkg.sv
// Shared definitions for the RPN token sequencer and the 3-bit-opcode LIFO calculator stack.
package stack_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {
    TK_OPERAND = 2'b00,
    TK_ADD     = 2'b01,
    TK_MUL     = 2'b10,
    TK_END     = 2'b11
  } tok_kind_e;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_UNDERFLOW = 3'd1,
    ERR_LEFTOVER  = 3'd2,
    ERR_ARITH_OVF = 3'd3,
    ERR_FULL      = 3'd4
  } err_e;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_WAIT1  = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_POP    = 3'd3,
    ST_CAPT   = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_RESULT = 3'd6
  } seq_state_e;

endpackage

// File: rtl/rpn_token_sequencer.sv
// Postfix token stream to stack-opcode sequencer with shadow depth tracking and error reporting.
// Optional RPN_PERF_CNT_EN adds perf_cycles (first accept to result latency of each expression).
module rpn_token_sequencer
  import stack_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tok_valid,
  output logic                    tok_ready,
  input  logic [1:0]              tok_kind,
  input  logic signed [WIDTH-1:0] tok_data,
  output logic [2:0]              stk_opcode,
  output logic signed [WIDTH-1:0] stk_data,
  input  logic signed [WIDTH-1:0] stk_out,
  input  logic                    stk_ovf,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] res_data,
  output logic [2:0]              res_err
`ifdef RPN_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] TWO       = DW'(2);

  seq_state_e    state, state_n;
  logic [DW-1:0] depth, depth_n;
  logic [2:0]    op_n;
  logic [2:0]    err_n;
  logic          push_ld;
  logic          res_cap;
  logic          res_zero;
  logic          accept;
  tok_kind_e     kind;

  assign accept    = tok_valid & tok_ready;
  assign kind      = tok_kind_e'(tok_kind);
  assign res_valid = (state == ST_RESULT);

  always_comb begin
    state_n  = state;
    depth_n  = depth;
    op_n     = OP_NOP;
    err_n    = res_err;
    push_ld  = 1'b0;
    res_cap  = 1'b0;
    res_zero = 1'b0;
    case (state)
      ST_RUN: begin
        if (accept) begin
          case (kind)
            TK_OPERAND: begin
              if (depth < DEPTH_MAX) begin
                op_n    = OP_PUSH;
                depth_n = depth + ONE;
                push_ld = 1'b1;
              end else begin
                err_n   = ERR_FULL;
                state_n = ST_DRAIN;
              end
            end
            TK_ADD, TK_MUL: begin
              if (depth >= TWO) begin
                op_n    = (kind == TK_ADD) ? OP_ADD : OP_MUL;
                depth_n = depth - ONE;
                state_n = ST_WAIT1;
              end else begin
                err_n   = ERR_UNDERFLOW;
                state_n = ST_DRAIN;
              end
            end
            default: begin
              if (depth == ONE) begin
                op_n    = OP_POP;
                depth_n = '0;
                state_n = ST_POP;
              end else if (depth == '0) begin
                err_n    = ERR_UNDERFLOW;
                res_zero = 1'b1;
                state_n  = ST_RESULT;
              end else begin
                err_n   = ERR_LEFTOVER;
                state_n = ST_DRAIN;
              end
            end
          endcase
        end
      end
      ST_WAIT1: state_n = ST_WAIT2;
      // Stack flag reflects the arithmetic op issued two edges earlier
      ST_WAIT2: begin
        if (stk_ovf) begin
          err_n   = ERR_ARITH_OVF;
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_POP:  state_n = ST_CAPT;
      ST_CAPT: begin
        res_cap = 1'b1;
        err_n   = ERR_OK;
        state_n = ST_RESULT;
      end
      ST_DRAIN: begin
        if (depth != '0) begin
          op_n    = OP_POP;
          depth_n = depth - ONE;
        end else begin
          res_zero = 1'b1;
          state_n  = ST_RESULT;
        end
      end
      ST_RESULT: if (res_ready) state_n = ST_RUN;
      default:   state_n = ST_RUN;
    endcase
  end

  // Issue / result register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      depth      <= '0;
      stk_opcode <= OP_NOP;
      stk_data   <= '0;
      tok_ready  <= 1'b0;
      res_data   <= '0;
      res_err    <= ERR_OK;
    end else begin
      state      <= state_n;
      depth      <= depth_n;
      stk_opcode <= op_n;
      tok_ready  <= (state_n == ST_RUN);
      res_err    <= err_n;
      if (push_ld) stk_data <= tok_data;
      if (res_cap) res_data <= stk_out;
      else if (res_zero) res_data <= '0;
    end
  end

`ifdef RPN_PERF_CNT_EN
  logic [31:0] perf_cnt;
  logic        perf_act;

  // Counts edges since the first accepted token; a result on the same edge reports zero
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt    <= '0;
      perf_act    <= 1'b0;
      perf_cycles <= '0;
    end else if ((state_n == ST_RESULT) && (state != ST_RESULT)) begin
      perf_cycles <= perf_act ? (perf_cnt + 32'd1) : 32'd0;
      perf_act    <= 1'b0;
    end else if (perf_act) begin
      perf_cnt <= perf_cnt + 32'd1;
    end else if (accept) begin
      perf_act <= 1'b1;
      perf_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_rpn_token_sequencer.sv
// Scoreboard bench for rpn_token_sequencer with a behavioural stack and a stream-level RPN model.
`timescale 1ns/1ps
module tb_rpn_token_sequencer;
  import stack_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tok_valid = 1'b0;
  logic tok_ready;
  logic [1:0] tok_kind = 2'b00;
  logic signed [WIDTH-1:0] tok_data = '0;
  logic [2:0] stk_opcode;
  logic signed [WIDTH-1:0] stk_data;
  logic signed [WIDTH-1:0] stk_out;
  logic stk_ovf;
  logic res_valid;
  logic res_ready;
  logic signed [WIDTH-1:0] res_data;
  logic [2:0] res_err;
`ifdef RPN_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  rpn_token_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_data(tok_data),
    .stk_opcode(stk_opcode), .stk_data(stk_data), .stk_out(stk_out), .stk_ovf(stk_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
`ifdef RPN_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] op; logic signed [WIDTH-1:0] data; } op_t;
  typedef struct { logic signed [WIDTH-1:0] data; logic [2:0] err; } res_t;

  op_t  exp_ops[$];
  res_t exp_res[$];
  logic signed [WIDTH-1:0] m_vals[$];
  logic signed [WIDTH-1:0] stk_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic hold_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not reached", nm);
  endfunction

  // Reference model: evaluates the token stream value by value
  function automatic void push_op(logic [2:0] op, logic signed [WIDTH-1:0] d);
    op_t o;
    o.op = op;
    o.data = d;
    exp_ops.push_back(o);
  endfunction

  function automatic void push_res(logic signed [WIDTH-1:0] d, logic [2:0] e);
    res_t r;
    r.data = d;
    r.err = e;
    exp_res.push_back(r);
  endfunction

  function automatic void model_fail(logic [2:0] e);
    for (int i = 0; i < m_vals.size(); i++) push_op(OP_POP, '0);
    m_vals.delete();
    push_res('0, e);
  endfunction

  function automatic void model_tok(logic [1:0] k, logic signed [WIDTH-1:0] d);
    longint a, b, r;
    logic signed [WIDTH-1:0] w;
    if (k == 2'b00) begin
      if (m_vals.size() < DEPTH) begin
        m_vals.push_back(d);
        push_op(OP_PUSH, d);
      end else model_fail(3'd4);
    end else if (k != 2'b11) begin
      if (m_vals.size() >= 2) begin
        a = m_vals.pop_back();
        b = m_vals.pop_back();
        r = (k == 2'b01) ? a + b : a * b;
        w = r[WIDTH-1:0];
        push_op((k == 2'b01) ? OP_ADD : OP_MUL, '0);
        m_vals.push_back(w);
        if (r > MAXV || r < MINV) model_fail(3'd3);
      end else model_fail(3'd1);
    end else begin
      if (m_vals.size() == 1) begin
        push_op(OP_POP, '0);
        push_res(m_vals[0], 3'd0);
        m_vals.delete();
      end else if (m_vals.size() == 0) push_res('0, 3'd1);
      else model_fail(3'd2);
    end
  endfunction

  // Behavioural downstream stack: executes the opcode registered on the previous edge
  longint sa, sb, sr;
  always @(posedge clk) begin
    if (rst) begin
      stk_q.delete();
      stk_out <= '0;
      stk_ovf <= 1'b0;
    end else begin
      case (stk_opcode)
        OP_PUSH: stk_q.push_back(stk_data);
        OP_POP:  if (stk_q.size() > 0) stk_out <= stk_q.pop_back();
        OP_ADD, OP_MUL: begin
          if (stk_q.size() >= 2) begin
            sa = stk_q.pop_back();
            sb = stk_q.pop_back();
            sr = (stk_opcode == OP_ADD) ? sa + sb : sa * sb;
            stk_q.push_back(sr[WIDTH-1:0]);
            stk_out <= sr[WIDTH-1:0];
            stk_ovf <= (sr > MAXV) || (sr < MINV);
          end
        end
        default: ;
      endcase
    end
  end

  // Opcode monitor
  op_t eo;
  always @(negedge clk) begin
    if (!rst && stk_opcode != OP_NOP) begin
      if (exp_ops.size() == 0) fail_now("unexpected_opcode");
      else begin
        eo = exp_ops.pop_front();
        chk("opcode", stk_opcode, eo.op);
        if (eo.op == OP_PUSH) chk("push_data", stk_data, eo.data);
      end
    end
  end

  // Result consumer and monitor
  res_t er;
  logic pend = 1'b0;
  logic signed [WIDTH-1:0] pd;
  logic [2:0] pe;
  always @(negedge clk) begin
    if (rst) begin
      res_ready = 1'b0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, pd);
        chk("hold_err", res_err, pe);
      end
      res_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      pend = 1'b0;
      if (res_valid) begin
        if (res_ready) begin
          if (exp_res.size() == 0) fail_now("unexpected_result");
          else begin
            er = exp_res.pop_front();
            chk("res_data", res_data, er.data);
            chk("res_err", res_err, er.err);
          end
        end else begin
          pend = 1'b1;
          pd = res_data;
          pe = res_err;
        end
      end
    end
  end

  task automatic send_tok(input logic [1:0] k, input logic signed [WIDTH-1:0] d);
    int n = 0;
    model_tok(k, d);
    tok_valid = 1'b1;
    tok_kind = k;
    tok_data = d;
    while (!tok_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("tok_accept_timeout");
    @(negedge clk);
    tok_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_res.size() != 0 || exp_ops.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_opcode", stk_opcode, OP_NOP);
    chk("rst_stk_data", stk_data, 0);
    chk("rst_tok_ready", tok_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n;
    logic [1:0] k;
    logic signed [WIDTH-1:0] d;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // 3 4 + end
    send_tok(2'b00, 32'sd3); send_tok(2'b00, 32'sd4); send_tok(2'b01, '0); send_tok(2'b11, '0);
    wait_idle();

    // back-to-back operands
    c0 = cyc;
    send_tok(2'b00, 32'sd1); send_tok(2'b00, 32'sd2); send_tok(2'b00, 32'sd3); send_tok(2'b00, 32'sd4);
    chk("b2b_cycles", cyc - c0, 4);
    send_tok(2'b01, '0); send_tok(2'b01, '0); send_tok(2'b01, '0); send_tok(2'b11, '0);
    wait_idle();

    // -3 4 * end, ready low two cycles after the mul
    send_tok(2'b00, -32'sd3); send_tok(2'b00, 32'sd4); send_tok(2'b10, '0);
    n = 0;
    while (!tok_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("mul_stall_cycles", n, 2);
    send_tok(2'b11, '0);
    wait_idle();

    // underflow: 5 +
    send_tok(2'b00, 32'sd5); send_tok(2'b01, '0);
    wait_idle();
    chk("underflow_stack_depth", stk_q.size(), 0);

    // arithmetic overflow
    send_tok(2'b00, 32'sh7FFFFFFF); send_tok(2'b00, 32'sd1); send_tok(2'b01, '0);
    wait_idle();
    chk("ovf_stack_depth", stk_q.size(), 0);

    // stack full: DEPTH+1 operands
    for (int i = 0; i <= DEPTH; i++) send_tok(2'b00, i + 1);
    wait_idle();
    chk("full_stack_depth", stk_q.size(), 0);

    // result held while consumer stalls
    hold_ready = 1'b1;
    send_tok(2'b00, 32'sd6); send_tok(2'b00, 32'sd7); send_tok(2'b10, '0); send_tok(2'b11, '0);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("hold_res_valid_timeout");
    repeat (5) @(negedge clk);
    hold_ready = 1'b0;
    wait_idle();

    // reset in the middle of an expression
    send_tok(2'b00, 32'sd9); send_tok(2'b00, 32'sd8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    m_vals.delete();
    exp_ops.delete();
    exp_res.delete();
    rst = 1'b0;
    @(negedge clk);
    send_tok(2'b00, 32'sd11); send_tok(2'b00, 32'sd12); send_tok(2'b01, '0); send_tok(2'b11, '0);
    wait_idle();

    // randomized token stream
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 9);
      if (n <= 4) k = 2'b00;
      else if (n <= 6) k = 2'b01;
      else if (n == 7) k = 2'b10;
      else k = 2'b11;
      n = $urandom_range(0, 3);
      if (n <= 1) d = $signed($urandom_range(0, 100)) - 32'sd50;
      else if (n == 2) d = $urandom;
      else d = $urandom_range(0, 1000);
      send_tok(k, d);
    end
    send_tok(2'b11, '0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
